// File: rtl/memory_stage_if.sv
// Shared pipeline/data-bus types and the data-bus interface used by the MEM stage.
// The initiator drives dreq, and the memory side answers on dresp.
package memory_stage_pkg;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;
    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   zeroextwb;
        msize_t memsize;
    } control_t;

    typedef struct packed {
        logic        valid;
        word_t       pc;
        logic [31:0] raw_instr;
        control_t    ctl;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  dst;
        word_t       aluout;
        word_t       memwd;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        word_t       pc;
        logic [31:0] raw_instr;
        control_t    ctl;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  dst;
        word_t       writedata;
        word_t       memaddr;
    } memory_data_t;

    typedef struct packed {
        logic    valid;
        word_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;
endpackage

interface memory_stage_if;
    import memory_stage_pkg::*;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/memory_stage.sv
// MEM stage: non-memory ops and misaligned accesses complete in 1 cycle; aligned loads/stores
// take 2+ cycles, and stall_o holds upstream until dresp.data_ok ends the bus access.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t ex_i,
    output memory_data_t  mem_o,
    memory_stage_if.master dbus,
    output logic          stall_o,
    output logic          misalign_o
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t        state, state_nxt;
    execute_data_t lat;
    logic          memop, misaligned;
    logic [5:0]    lat_sh;
    word_t         shifted, load_val;
    strobe_t       base_strobe;
    logic          unused_addr_ok;

    assign unused_addr_ok = dbus.dresp.addr_ok;

    function automatic logic is_misaligned(input msize_t sz, input logic [2:0] a);
        case (sz)
            MSIZE2:  return a[0];
            MSIZE4:  return a[1:0] != 2'b00;
            MSIZE8:  return a[2:0] != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

    function automatic memory_data_t pass(input execute_data_t e, input word_t wd);
        memory_data_t m;
        m.valid     = 1'b1;
        m.pc        = e.pc;
        m.raw_instr = e.raw_instr;
        m.ctl       = e.ctl;
        m.ra1       = e.ra1;
        m.ra2       = e.ra2;
        m.dst       = e.dst;
        m.writedata = wd;
        m.memaddr   = e.aluout;
        return m;
    endfunction

    assign memop      = ex_i.valid & (ex_i.ctl.memread | ex_i.ctl.memwrite);
    assign misaligned = is_misaligned(ex_i.ctl.memsize, ex_i.aluout[2:0]);
    assign lat_sh     = {lat.aluout[2:0], 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (memop && !misaligned) state_nxt = REQ;
            REQ:     if (dbus.dresp.data_ok)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields come only from the latched instruction so they stay put across wait cycles.
    always_comb begin
        dbus.dreq = '0;
        stall_o   = 1'b0;
        case (lat.ctl.memsize)
            MSIZE1:  base_strobe = 8'h01;
            MSIZE2:  base_strobe = 8'h03;
            MSIZE4:  base_strobe = 8'h0F;
            default: base_strobe = 8'hFF;
        endcase
        if (state == REQ) begin
            dbus.dreq.valid = 1'b1;
            dbus.dreq.addr  = lat.aluout;
            dbus.dreq.size  = lat.ctl.memsize;
            if (lat.ctl.memwrite) begin
                dbus.dreq.strobe = base_strobe << lat.aluout[2:0];
                dbus.dreq.data   = lat.memwd << lat_sh;
            end
            stall_o = !dbus.dresp.data_ok;
        end else begin
            stall_o = memop && !misaligned;
        end
    end

    always_comb begin
        shifted = dbus.dresp.data >> lat_sh;
        case (lat.ctl.memsize)
            MSIZE1:  load_val = lat.ctl.zeroextwb ? {56'd0, shifted[7:0]}
                                                  : {{56{shifted[7]}}, shifted[7:0]};
            MSIZE2:  load_val = lat.ctl.zeroextwb ? {48'd0, shifted[15:0]}
                                                  : {{48{shifted[15]}}, shifted[15:0]};
            MSIZE4:  load_val = lat.ctl.zeroextwb ? {32'd0, shifted[31:0]}
                                                  : {{32{shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_o      <= '0;
            misalign_o <= 1'b0;
            lat        <= '0;
        end else begin
            mem_o.valid <= 1'b0;
            misalign_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_i.valid && !memop) begin
                        mem_o <= pass(ex_i, ex_i.aluout);
                    end else if (memop && misaligned) begin
                        mem_o              <= pass(ex_i, '0);
                        mem_o.ctl.regwrite <= 1'b0;
                        misalign_o         <= 1'b1;
                    end else if (memop) begin
                        lat <= ex_i;
                    end
                end
                REQ: begin
                    if (dbus.dresp.data_ok)
                        mem_o <= pass(lat, lat.ctl.memwrite ? lat.aluout : load_val);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed vector table, hand sequences for reset/back-to-back, and
// random transactions checked against a byte-arithmetic reference model.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t ex_drv;
    memory_data_t  mem_o;
    logic          stall_o, misalign_o;
    int            n_vec = 0;
    int            n_err = 0;

    memory_stage_if bus();

    memory_stage dut (
        .clk(clk), .reset(reset), .ex_i(ex_drv), .mem_o(mem_o),
        .dbus(bus), .stall_o(stall_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic execute_data_t mk(input logic rd, input logic wr, input logic zx,
                                         input msize_t sz, input word_t addr, input word_t wd,
                                         input logic regw);
        execute_data_t e;
        e.valid         = 1'b1;
        e.pc            = 64'h8000_1000 + {32'd0, $urandom_range(0, 255)} * 4;
        e.raw_instr     = $urandom;
        e.ctl.regwrite  = regw;
        e.ctl.memread   = rd;
        e.ctl.memwrite  = wr;
        e.ctl.zeroextwb = zx;
        e.ctl.memsize   = sz;
        e.ra1           = 5'($urandom);
        e.ra2           = 5'($urandom);
        e.dst           = 5'($urandom);
        e.aluout        = addr;
        e.memwd         = wd;
        return e;
    endfunction

    // Reference: byte counts, offsets and masks computed arithmetically.
    task automatic model(input execute_data_t e, input word_t rdata, output memory_data_t m,
                         output logic mis, output dbus_req_t r);
        int    nbytes = 1 << int'(e.ctl.memsize);
        int    off = int'(e.aluout[2:0]);
        logic  mop = e.ctl.memread | e.ctl.memwrite;
        word_t mask, v;
        mask = (nbytes == 8) ? ~64'd0 : ((64'd1 << (8 * nbytes)) - 64'd1);
        mis  = mop && (off % nbytes != 0);
        m = '{valid: 1'b1, pc: e.pc, raw_instr: e.raw_instr, ctl: e.ctl, ra1: e.ra1,
              ra2: e.ra2, dst: e.dst, writedata: e.aluout, memaddr: e.aluout};
        r = '{valid: 1'b1, addr: e.aluout, size: e.ctl.memsize, strobe: 8'h00, data: 64'd0};
        if (mis) begin
            m.writedata    = 64'd0;
            m.ctl.regwrite = 1'b0;
        end else if (e.ctl.memwrite) begin
            r.data   = e.memwd << (8 * off);
            r.strobe = 8'(((1 << nbytes) - 1) << off);
        end else if (e.ctl.memread) begin
            v = (rdata >> (8 * off)) & mask;
            if (!e.ctl.zeroextwb && v[8 * nbytes - 1]) v = v | ~mask;
            m.writedata = v;
        end
    endtask

    // Presents one instruction, waits `waits` cycles before data_ok, checks every cycle.
    task automatic run_txn(input string nm, input execute_data_t e, input word_t rdata,
                           input int waits, input memory_data_t exp_m, input logic exp_mis,
                           input dbus_req_t exp_r);
        logic acc = (e.ctl.memread | e.ctl.memwrite) && !exp_mis;
        @(negedge clk);
        bus.dresp = '0;
        ex_drv    = e;
        #1;
        chk({nm, ".stall_accept"}, 256'(stall_o), 256'(acc));
        chk({nm, ".dreq_idle"}, 256'(bus.dreq.valid), 256'(0));
        @(posedge clk); #1;
        if (!acc) begin
            chk({nm, ".mem_o"}, 256'(mem_o), 256'(exp_m));
            chk({nm, ".misalign"}, 256'(misalign_o), 256'(exp_mis));
            chk({nm, ".dreq_none"}, 256'(bus.dreq.valid), 256'(0));
        end else begin
            chk({nm, ".mem_o_pending"}, 256'(mem_o.valid), 256'(0));
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                bus.dresp.addr_ok = 1'($urandom);
                bus.dresp.data_ok = (w == waits);
                bus.dresp.data    = (w == waits) ? rdata : {$urandom, $urandom};
                if (w == waits) ex_drv = e;
                else begin
                    ex_drv.aluout = {$urandom, $urandom};
                    ex_drv.memwd  = {$urandom, $urandom};
                end
                #1;
                chk({nm, ".dreq"}, 256'(bus.dreq), 256'(exp_r));
                chk({nm, ".stall_req"}, 256'(stall_o), 256'(w != waits));
                @(posedge clk); #1;
                if (w < waits) chk({nm, ".mem_o_wait"}, 256'(mem_o.valid), 256'(0));
            end
            chk({nm, ".mem_o"}, 256'(mem_o), 256'(exp_m));
            chk({nm, ".misalign"}, 256'(misalign_o), 256'(0));
        end
    endtask

    task automatic idle(input logic stray_ok);
        @(negedge clk);
        ex_drv.valid      = 1'b0;
        bus.dresp         = '0;
        bus.dresp.data_ok = stray_ok;
        @(posedge clk); #1;
        chk("idle.mem_o_valid", 256'(mem_o.valid), 256'(0));
        chk("idle.dreq_valid", 256'(bus.dreq.valid), 256'(0));
    endtask

    typedef struct {
        string         name;
        execute_data_t ex;
        word_t         rdata;
        int            waits;
        word_t         exp_wd;
        logic          exp_mis;
        strobe_t       exp_strobe;
        word_t         exp_ddata;
    } vec_t;

    task automatic run_vec(input vec_t v);
        memory_data_t m;
        dbus_req_t    r;
        m = '{valid: 1'b1, pc: v.ex.pc, raw_instr: v.ex.raw_instr, ctl: v.ex.ctl, ra1: v.ex.ra1,
              ra2: v.ex.ra2, dst: v.ex.dst, writedata: v.exp_wd, memaddr: v.ex.aluout};
        m.ctl.regwrite = v.ex.ctl.regwrite & !v.exp_mis;
        r = '{valid: 1'b1, addr: v.ex.aluout, size: v.ex.ctl.memsize,
              strobe: v.exp_strobe, data: v.exp_ddata};
        run_txn(v.name, v.ex, v.rdata, v.waits, m, v.exp_mis, r);
    endtask

    initial begin
        vec_t         tbl[6];
        memory_data_t m, m2;
        dbus_req_t    r, r2;
        logic         mis;
        execute_data_t e, e2;
        word_t        rd, rd2;

        tbl[0] = '{"add", mk(0, 0, 0, MSIZE8, 64'd5, 64'd0, 1), 64'd0, 0, 64'd5, 0, 8'h00, 64'd0};
        tbl[1] = '{"lb", mk(1, 0, 0, MSIZE1, 64'h8000_0003, 64'd0, 1), 64'h0000_0000_8000_0000, 2,
                   64'hFFFF_FFFF_FFFF_FF80, 0, 8'h00, 64'd0};
        tbl[2] = '{"lbu", mk(1, 0, 1, MSIZE1, 64'h8000_0003, 64'd0, 1), 64'h0000_0000_8000_0000, 2,
                   64'h80, 0, 8'h00, 64'd0};
        tbl[3] = '{"sh", mk(0, 1, 0, MSIZE2, 64'h8000_0006, 64'h1234, 0), 64'd0, 3,
                   64'h8000_0006, 0, 8'hC0, 64'h1234_0000_0000_0000};
        tbl[4] = '{"lw_mis", mk(1, 0, 0, MSIZE4, 64'h8000_0002, 64'd0, 1), 64'd0, 0, 64'd0, 1,
                   8'h00, 64'd0};
        tbl[5] = '{"lw_neg", mk(1, 0, 0, MSIZE4, 64'h8000_0004, 64'd0, 1), 64'h8765_4321_0000_0000,
                   1, 64'hFFFF_FFFF_8765_4321, 0, 8'h00, 64'd0};

        reset     = 1'b1;
        ex_drv    = '0;
        bus.dresp = '0;
        #3;
        chk("reset.mem_o", 256'(mem_o), 256'(0));
        chk("reset.dreq", 256'(bus.dreq), 256'(0));
        chk("reset.misalign", 256'(misalign_o), 256'(0));
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i]);
            idle(1'b0);
        end

        idle(1'b1);  // stray data_ok while idle must do nothing

        // Back-to-back LDs with data_ok in the first REQ cycle: results at t+2 and t+4.
        e  = mk(1, 0, 0, MSIZE8, 64'h8, 64'd0, 1);
        e2 = mk(1, 0, 0, MSIZE8, 64'h10, 64'd0, 1);
        rd  = 64'hDEAD_BEEF_0123_4567;
        rd2 = 64'h0BAD_F00D_89AB_CDEF;
        model(e, rd, m, mis, r);
        model(e2, rd2, m2, mis, r2);
        run_txn("b2b_ld0", e, rd, 0, m, 1'b0, r);
        run_txn("b2b_ld1", e2, rd2, 0, m2, 1'b0, r2);
        idle(1'b0);

        // Reset while a request is outstanding.
        e = mk(1, 0, 0, MSIZE8, 64'h20, 64'd0, 1);
        @(negedge clk); ex_drv = e; bus.dresp = '0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("rst_req.dreq_before", 256'(bus.dreq.valid), 256'(1));
        reset = 1'b1;
        #1;
        chk("rst_req.dreq_after", 256'(bus.dreq.valid), 256'(0));
        chk("rst_req.mem_o_valid", 256'(mem_o.valid), 256'(0));
        ex_drv.valid = 1'b0;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        run_vec(tbl[0]);
        idle(1'b0);

        for (int i = 0; i < 200; i++) begin
            int    op = $urandom_range(0, 2);
            msize_t sz = msize_t'($urandom_range(0, 3));
            word_t a  = {32'h0, 32'h8000_0000 | $urandom};
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
            e  = mk(op == 1, op == 2, 1'($urandom), sz, a, {$urandom, $urandom}, 1'($urandom));
            rd = {$urandom, $urandom};
            model(e, rd, m, mis, r);
            run_txn("rand", e, rd, $urandom_range(0, 3), m, mis, r);
            if ($urandom_range(0, 3) == 0) idle(1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
